// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory arbiter in front of mem_control.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_ARD} owner_t;

    typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive cpu wins while the debug port is waiting.
module arb_starve_ctr #(
    parameter int unsigned MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_max = (cnt_q == W'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer sharing the mem_control port between the cpu and the
// debug port; one access in flight at a time: arbitrate, issue, wait, respond.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_vec,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  lane_vec_t         cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output lane_vec_t         cpu_rdata,
    input  logic              ard_req,
    input  logic              ard_we,
    input  logic [ADDR_W-1:0] ard_addr,
    input  logic [DATA_W-1:0] ard_wdata,
    output logic              ard_gnt,
    output logic              ard_rvalid,
    output logic [DATA_W-1:0] ard_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_vec,
    output lane_vec_t         mem_wdata,
    input  lane_vec_t         mem_rdata
);

    localparam int unsigned LAT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic              vec_q, vec_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    lane_vec_t         wdata_q, wdata_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    lane_vec_t         cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ard_rdata_q, ard_rdata_d;

    logic cpu_win, ard_win, at_max, busy;

    // cpu has priority until the debug port has been passed over STARVE_MAX times in a row.
    assign cpu_win = cpu_req && (!ard_req || !at_max);
    assign ard_win = ard_req && !cpu_win;

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    ((state_q == IDLE) && cpu_win && ard_req),
        .clr    ((state_q == IDLE) && (ard_win || !ard_req)),
        .at_max (at_max)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        vec_d       = vec_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_cnt_d   = lat_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        ard_rdata_d = ard_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_win) begin
                    state_d = ISSUE;
                    owner_d = OWN_CPU;
                    we_d    = cpu_we;
                    vec_d   = cpu_vec;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                end else if (ard_win) begin
                    state_d    = ISSUE;
                    owner_d    = OWN_ARD;
                    we_d       = ard_we;
                    vec_d      = 1'b0;
                    addr_d     = ard_addr;
                    wdata_d    = '0;
                    wdata_d[0] = ard_wdata;
                end
            end
            ISSUE: begin
                if (MEM_LAT > 1) begin
                    state_d   = WAIT;
                    lat_cnt_d = LAT_W'(MEM_LAT - 2);
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (owner_q == OWN_CPU) begin
                    cpu_rdata_d = mem_rdata;
                end else begin
                    ard_rdata_d = mem_rdata[0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            vec_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_cnt_q   <= '0;
            cpu_rdata_q <= '0;
            ard_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            vec_q       <= vec_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_cnt_q   <= lat_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            ard_rdata_q <= ard_rdata_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign cpu_gnt    = (state_q == ISSUE) && (owner_q == OWN_CPU);
    assign ard_gnt    = (state_q == ISSUE) && (owner_q == OWN_ARD);
    assign cpu_rvalid = (state_q == DONE) && (owner_q == OWN_CPU);
    assign ard_rvalid = (state_q == DONE) && (owner_q == OWN_ARD);

    // Read data is forwarded during DONE so it is valid alongside rvalid, then held.
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign ard_rdata  = ard_rvalid ? mem_rdata[0] : ard_rdata_q;

    assign mem_addr   = busy ? addr_q : '0;
    assign mem_we     = (state_q == ISSUE) && we_q;
    assign mem_vec    = busy && vec_q;
    assign mem_wdata  = busy ? wdata_q : '0;

endmodule
